cgra_cfg_fetch: RTL and testbench
=================================

Name: cgra_cfg_fetch

Overview:
- Configuration-fetch stage feeding the CGRA interface.
- On a start pulse, it reads a contiguous block of 32-bit configuration words from system memory over an OBI master read channel.
- Words are buffered in a small FIFO and presented downstream as a valid/ready stream with a last marker.
- Register programming (base, count, start) is done by the owning register decoder; this block only sees decoded strobes.

Parameters:
- FIFO_DEPTH, 4, buffer depth in words; must be >= 2. Also caps requests in flight plus words buffered.
- CNT_W, 10, width of the word-count field; max transfer is 2^CNT_W-1 words.

Ports:
- clk_i  in  1  clock
- rst_i  in  1  reset, asynchronous, active-high
- start_i  in  1  one-cycle start strobe
- base_addr_i  in  32  byte address of first word, sampled on accepted start_i
- word_cnt_i  in  CNT_W  number of words, sampled on accepted start_i
- busy_o  out  1  high from accepted start until done
- done_o  out  1  one-cycle pulse at completion
- obi_req_o  out  1  OBI request
- obi_addr_o  out  32  OBI address
- obi_we_o  out  1  always 0
- obi_be_o  out  4  always 4'b1111
- obi_wdata_o  out  32  always 0
- obi_gnt_i  in  1  OBI grant
- obi_rvalid_i  in  1  OBI read response valid
- obi_rdata_i  in  32  OBI read data
- cfg_valid_o  out  1  stream word valid
- cfg_data_o  out  32  stream word
- cfg_last_o  out  1  marks final word of transfer
- cfg_ready_i  in  1  downstream ready

Behaviour:
- Reset: all outputs 0. State IDLE, all counters 0, FIFO empty. An asserted rst_i mid-transfer clears everything immediately; obi_req_o drops asynchronously. Responses to requests in flight at reset are not this block's concern.
- FSM states: IDLE, FETCH, DRAIN.
- IDLE:
  - start_i=1 with word_cnt_i!=0: load addr_q=base_addr_i, req_left=word_cnt_i, out_left=word_cnt_i; go to FETCH; busy_o=1 from the next cycle.
  - start_i=1 with word_cnt_i==0: no OBI traffic; done_o pulses the next cycle; busy_o stays 0.
- start_i while busy_o=1 is ignored, with no effect on the running transfer.
- FETCH:
  - Condition A: req_left!=0 and (outstanding + fifo_count) < FIFO_DEPTH. Asserting obi_req_o is allowed only when A holds.
  - Once asserted, obi_req_o and obi_addr_o hold stable until obi_gnt_i. The credit cannot shrink while req is held.
  - On req&gnt: addr_q += 4 (wraps modulo 2^32), req_left -= 1, outstanding += 1.
  - On req_left reaching 0 after a grant: go to DRAIN.
  - First obi_req_o is in the cycle after the accepted start_i.
- Outstanding counter: width clog2(FIFO_DEPTH+1). outstanding += (req&gnt) - rvalid, with simultaneous events netted.
- obi_rvalid_i pushes obi_rdata_i into the FIFO. Overflow is impossible by the credit rule. rvalid while outstanding==0 is a protocol error; flag it with an assertion and do not push.
- FIFO:
  - Registered; cfg_valid_o rises the cycle after the rvalid that filled an empty FIFO.
  - Pop on cfg_valid_o & cfg_ready_i.
  - Push and pop in the same cycle are both honoured, leaving the count unchanged.
- Stream:
  - cfg_data_o and cfg_valid_o hold stable while cfg_ready_i=0.
  - cfg_last_o = cfg_valid_o & (out_left==1).
  - out_left decrements on each stream handshake.
- DRAIN: no new requests. When the last word handshakes (out_left 1→0), go to IDLE. done_o pulses in the following cycle and busy_o falls in that same cycle.
- Response ordering is in-order per OBI; no reordering logic.

Test Plan:
- Basic transfer: base=0x1000, cnt=3, gnt and rvalid one cycle after req, cfg_ready=1 → addresses 0x1000, 0x1004, 0x1008 in order; stream words match memory; cfg_last_o only on the 3rd word; one done_o pulse; busy_o low afterwards.
- Backpressure: cnt=8, FIFO_DEPTH=4, cfg_ready_i=0 → after 4 grants obi_req_o stays 0; fifo_count + outstanding never exceeds 4; releasing ready completes all 8 words in order.
- Delayed grant: gnt withheld for 5 cycles → obi_req_o stays 1 with a stable address; exactly one grant counted per word.
- Zero count: start with cnt=0 → no obi_req_o; done_o pulses the next cycle; busy_o stays 0.
- Start while busy, then reset mid-operation:
  - A second start_i during a cnt=4 transfer is ignored, and exactly 4 words are output.
  - rst_i pulsed during FETCH → obi_req_o, cfg_valid_o and busy_o read 0 while reset is asserted.
  - A fresh start after reset fetches from the new base.
- Wrap: base=0xFFFFFFF8, cnt=3 → addresses 0xFFFFFFF8, 0xFFFFFFFC, 0x00000000.

Source files
------------

// File: rtl/cgra_cfg_fetch.sv
// ---------------------------------------------------------------------------
// cgra_cfg_fetch
//   Configuration-fetch stage for the CGRA. A start strobe launches an OBI
//   read burst over a contiguous block of 32-bit words. Returned words are
//   buffered in a small FIFO and presented downstream as a valid/ready
//   stream with a last marker on the final word of the block.
//
// Ports
//   clk_i, rst_i          clock, asynchronous active-high reset
//   start_i               one-cycle start strobe (ignored while busy_o=1)
//   base_addr_i           byte address of first word, sampled on start
//   word_cnt_i            number of words, sampled on start
//   busy_o                high from accepted start until done
//   done_o                one-cycle completion pulse
//   obi_*                 OBI master read channel (writes never issued)
//   cfg_valid_o/ready_i   downstream stream handshake
//   cfg_data_o/last_o     stream word and final-word marker
//   dbg_state_o           current FSM state (IDLE=0, FETCH=1, DRAIN=2)
//
// Handshakes: a transfer happens on any rising clk_i edge where valid (req)
// and ready (gnt) are both high. Once raised, valid and its payload hold
// stable until that edge; ready may be raised or dropped at any time.
// ---------------------------------------------------------------------------
module cgra_cfg_fetch #(
   parameter int unsigned FIFO_DEPTH = 4,
   parameter int unsigned CNT_W      = 10
) (
   input  logic             clk_i,
   input  logic             rst_i,
   input  logic             start_i,
   input  logic [31:0]      base_addr_i,
   input  logic [CNT_W-1:0] word_cnt_i,
   output logic             busy_o,
   output logic             done_o,
   output logic             obi_req_o,
   output logic [31:0]      obi_addr_o,
   output logic             obi_we_o,
   output logic [3:0]       obi_be_o,
   output logic [31:0]      obi_wdata_o,
   input  logic             obi_gnt_i,
   input  logic             obi_rvalid_i,
   input  logic [31:0]      obi_rdata_i,
   output logic             cfg_valid_o,
   output logic [31:0]      cfg_data_o,
   output logic             cfg_last_o,
   input  logic             cfg_ready_i,
   output logic [1:0]       dbg_state_o
);

   localparam int unsigned PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
   localparam int unsigned CW    = $clog2(FIFO_DEPTH + 1);
   localparam logic [CW:0] DEPTH_L = FIFO_DEPTH[CW:0];

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      FETCH = 2'd1,
      DRAIN = 2'd2
   } state_e;

   state_e           state_q, state_d;
   logic [31:0]      addr_q, addr_d;
   logic [CNT_W-1:0] req_left_q, req_left_d;
   logic [CNT_W-1:0] out_left_q, out_left_d;
   logic [CW-1:0]    outstanding_q, outstanding_d;
   logic [CW-1:0]    fifo_cnt_q, fifo_cnt_d;
   logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
   logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
   logic [31:0]      mem_q [FIFO_DEPTH];
   logic [31:0]      mem_d [FIFO_DEPTH];
   logic             done_q, done_d;

   logic [CW:0]      inflight;
   logic             credit_ok;
   logic             grant;
   logic             push;
   logic             pop;

   function automatic logic [PTR_W-1:0] next_ptr(input logic [PTR_W-1:0] p);
      next_ptr = (p == PTR_W'(FIFO_DEPTH - 1)) ? '0 : p + PTR_W'(1);
   endfunction

   // Requests in flight plus words already buffered may never exceed the
   // FIFO depth, so every response is guaranteed a slot. While a request is
   // held without grant this sum can only fall, so req never retracts.
   assign inflight  = {1'b0, outstanding_q} + {1'b0, fifo_cnt_q};
   assign credit_ok = inflight < DEPTH_L;

   assign obi_req_o   = (state_q == FETCH) && (req_left_q != '0) && credit_ok;
   assign obi_addr_o  = addr_q;
   assign obi_we_o    = 1'b0;
   assign obi_be_o    = 4'b1111;
   assign obi_wdata_o = 32'h0;

   assign grant = obi_req_o & obi_gnt_i;
   // A stray response with nothing outstanding is dropped, not buffered.
   assign push  = obi_rvalid_i && (outstanding_q != '0);
   assign pop   = cfg_valid_o & cfg_ready_i;

   assign cfg_valid_o = (fifo_cnt_q != '0);
   assign cfg_data_o  = mem_q[rd_ptr_q];
   assign cfg_last_o  = cfg_valid_o && (out_left_q == CNT_W'(1));

   assign busy_o      = (state_q != IDLE);
   assign done_o      = done_q;
   assign dbg_state_o = state_q;

   always_comb begin
      state_d       = state_q;
      addr_d        = addr_q;
      req_left_d    = req_left_q;
      out_left_d    = out_left_q;
      done_d        = 1'b0;
      outstanding_d = outstanding_q + CW'(grant) - CW'(push);
      fifo_cnt_d    = fifo_cnt_q + CW'(push) - CW'(pop);
      wr_ptr_d      = push ? next_ptr(wr_ptr_q) : wr_ptr_q;
      rd_ptr_d      = pop  ? next_ptr(rd_ptr_q) : rd_ptr_q;
      mem_d         = mem_q;
      if (push) begin
         mem_d[wr_ptr_q] = obi_rdata_i;
      end
      if (pop) begin
         out_left_d = out_left_q - CNT_W'(1);
      end

      case (state_q)
         IDLE: begin
            if (start_i) begin
               if (word_cnt_i != '0) begin
                  addr_d     = base_addr_i;
                  req_left_d = word_cnt_i;
                  out_left_d = word_cnt_i;
                  state_d    = FETCH;
               end else begin
                  done_d = 1'b1;
               end
            end
         end
         FETCH: begin
            if (grant) begin
               addr_d     = addr_q + 32'd4;
               req_left_d = req_left_q - CNT_W'(1);
               if (req_left_q == CNT_W'(1)) begin
                  state_d = DRAIN;
               end
            end
         end
         DRAIN: begin
            if (pop && (out_left_q == CNT_W'(1))) begin
               state_d = IDLE;
               done_d  = 1'b1;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         state_q       <= IDLE;
         addr_q        <= '0;
         req_left_q    <= '0;
         out_left_q    <= '0;
         outstanding_q <= '0;
         fifo_cnt_q    <= '0;
         wr_ptr_q      <= '0;
         rd_ptr_q      <= '0;
         done_q        <= 1'b0;
         for (int i = 0; i < int'(FIFO_DEPTH); i++) begin
            mem_q[i] <= '0;
         end
      end else begin
         state_q       <= state_d;
         addr_q        <= addr_d;
         req_left_q    <= req_left_d;
         out_left_q    <= out_left_d;
         outstanding_q <= outstanding_d;
         fifo_cnt_q    <= fifo_cnt_d;
         wr_ptr_q      <= wr_ptr_d;
         rd_ptr_q      <= rd_ptr_d;
         done_q        <= done_d;
         mem_q         <= mem_d;
      end
   end

   // A read response with no request outstanding breaks the OBI protocol.
   rvalid_without_request: assert property (
      @(posedge clk_i) disable iff (rst_i) !(obi_rvalid_i && (outstanding_q == '0)));

endmodule

// File: tb/tb_cgra_cfg_fetch.sv
// ---------------------------------------------------------------------------
// tb_cgra_cfg_fetch
//   Directed bench for cgra_cfg_fetch: an OBI slave model with programmable
//   grant delay (rvalid one cycle after grant), a stream sink with
//   programmable ready, and monitors that log addresses, words and pulses.
//   All inputs change and all outputs are sampled on the falling clock edge.
// ---------------------------------------------------------------------------
module tb_cgra_cfg_fetch;

   localparam int FIFO_DEPTH = 4;
   localparam int CNT_W      = 10;

   logic             clk_i        = 1'b0;
   logic             rst_i        = 1'b1;
   logic             start_i      = 1'b0;
   logic [31:0]      base_addr_i  = '0;
   logic [CNT_W-1:0] word_cnt_i   = '0;
   logic             busy_o;
   logic             done_o;
   logic             obi_req_o;
   logic [31:0]      obi_addr_o;
   logic             obi_we_o;
   logic [3:0]       obi_be_o;
   logic [31:0]      obi_wdata_o;
   logic             obi_gnt_i    = 1'b0;
   logic             obi_rvalid_i = 1'b0;
   logic [31:0]      obi_rdata_i  = '0;
   logic             cfg_valid_o;
   logic [31:0]      cfg_data_o;
   logic             cfg_last_o;
   logic             cfg_ready_i  = 1'b0;
   logic [1:0]       dbg_state_o;

   cgra_cfg_fetch #(.FIFO_DEPTH(FIFO_DEPTH), .CNT_W(CNT_W)) dut (
      .clk_i        (clk_i),
      .rst_i        (rst_i),
      .start_i      (start_i),
      .base_addr_i  (base_addr_i),
      .word_cnt_i   (word_cnt_i),
      .busy_o       (busy_o),
      .done_o       (done_o),
      .obi_req_o    (obi_req_o),
      .obi_addr_o   (obi_addr_o),
      .obi_we_o     (obi_we_o),
      .obi_be_o     (obi_be_o),
      .obi_wdata_o  (obi_wdata_o),
      .obi_gnt_i    (obi_gnt_i),
      .obi_rvalid_i (obi_rvalid_i),
      .obi_rdata_i  (obi_rdata_i),
      .cfg_valid_o  (cfg_valid_o),
      .cfg_data_o   (cfg_data_o),
      .cfg_last_o   (cfg_last_o),
      .cfg_ready_i  (cfg_ready_i),
      .dbg_state_o  (dbg_state_o)
   );

   // ---------------- clock / reset ----------------
   initial begin
      forever #5 clk_i = ~clk_i;
   end

   initial begin
      #400000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   // ---------------- scoreboard state ----------------
   int          vectors     = 0;
   int          miscompares = 0;
   logic [31:0] exp_q[$];

   logic [31:0] addr_log[$];
   logic [31:0] data_log[$];
   logic        last_log[$];
   int          gnt_delay    = 0;
   int          wait_cnt     = 0;
   int          grant_cnt    = 0;
   int          pop_cnt      = 0;
   int          stall_cycles = 0;
   int          stable_err   = 0;
   int          done_cnt     = 0;
   int          req_seen     = 0;
   int          max_inflight = 0;
   logic        ready_en     = 1'b1;
   logic        holding      = 1'b0;
   logic [31:0] held_addr    = '0;
   logic        gnt_prev     = 1'b0;
   logic [31:0] addr_prev    = '0;

   function automatic logic [31:0] mem_word(input logic [31:0] a);
      mem_word = a ^ 32'hA5A5_5A5A;
   endfunction

   task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
      vectors++;
      if (got !== exp) begin
         miscompares++;
         $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
      end
   endtask

   // ---------------- OBI slave model ----------------
   initial begin
      forever begin
         @(negedge clk_i);
         if (rst_i) begin
            obi_gnt_i    = 1'b0;
            obi_rvalid_i = 1'b0;
            obi_rdata_i  = '0;
            gnt_prev     = 1'b0;
            wait_cnt     = 0;
            holding      = 1'b0;
         end else begin
            obi_rvalid_i = gnt_prev;
            obi_rdata_i  = gnt_prev ? mem_word(addr_prev) : 32'h0;
            if (holding && (!obi_req_o || obi_addr_o !== held_addr)) stable_err++;
            if (obi_req_o) begin
               req_seen++;
               if (wait_cnt >= gnt_delay) begin
                  obi_gnt_i = 1'b1;
                  wait_cnt  = 0;
                  holding   = 1'b0;
                  addr_log.push_back(obi_addr_o);
                  grant_cnt++;
               end else begin
                  obi_gnt_i = 1'b0;
                  wait_cnt++;
                  holding   = 1'b1;
                  held_addr = obi_addr_o;
                  stall_cycles++;
               end
            end else begin
               obi_gnt_i = 1'b0;
               holding   = 1'b0;
            end
            gnt_prev  = obi_gnt_i;
            addr_prev = obi_addr_o;
         end
      end
   end

   // ---------------- stream sink and monitors ----------------
   initial begin
      forever begin
         @(negedge clk_i);
         cfg_ready_i = ready_en;
         if (!rst_i && cfg_valid_o && cfg_ready_i) begin
            data_log.push_back(cfg_data_o);
            last_log.push_back(cfg_last_o);
            pop_cnt++;
         end
         if (done_o) done_cnt++;
         #1;
         if (grant_cnt - pop_cnt > max_inflight) max_inflight = grant_cnt - pop_cnt;
      end
   end

   // ---------------- driver tasks ----------------
   task automatic clear_logs();
      addr_log.delete();
      data_log.delete();
      last_log.delete();
      grant_cnt    = 0;
      pop_cnt      = 0;
      stall_cycles = 0;
      stable_err   = 0;
      done_cnt     = 0;
      req_seen     = 0;
      max_inflight = 0;
   endtask

   // Called at a falling edge; returns at the falling edge after start is sampled.
   task automatic do_start(input logic [31:0] base, input logic [CNT_W-1:0] cnt);
      start_i     = 1'b1;
      base_addr_i = base;
      word_cnt_i  = cnt;
      @(negedge clk_i);
      start_i     = 1'b0;
   endtask

   task automatic wait_done(input string tag, input int budget);
      int n;
      n = 0;
      while (!done_o && n < budget) begin
         @(negedge clk_i);
         n++;
      end
      check_val({tag, "_done_seen"}, 32'(done_o), 32'd1);
      check_val({tag, "_busy_at_done"}, 32'(busy_o), 32'd0);
   endtask

   task automatic check_xfer(input string tag, input logic [31:0] base, input int cnt);
      exp_q.delete();
      for (int i = 0; i < cnt; i++) exp_q.push_back(base + 32'(4 * i));
      check_val({tag, "_addr_count"}, 32'(addr_log.size()), 32'(cnt));
      for (int i = 0; i < cnt; i++)
         if (i < addr_log.size()) check_val($sformatf("%s_addr%0d", tag, i), addr_log[i], exp_q[i]);
      exp_q.delete();
      for (int i = 0; i < cnt; i++) exp_q.push_back(mem_word(base + 32'(4 * i)));
      check_val({tag, "_word_count"}, 32'(data_log.size()), 32'(cnt));
      for (int i = 0; i < cnt; i++) begin
         if (i < data_log.size()) begin
            check_val($sformatf("%s_data%0d", tag, i), data_log[i], exp_q[i]);
            check_val($sformatf("%s_last%0d", tag, i), 32'(last_log[i]), 32'(i == cnt - 1));
         end
      end
   endtask

   // ---------------- directed sequence ----------------
   initial begin
      repeat (3) @(negedge clk_i);
      check_val("rst_req",   32'(obi_req_o),   32'd0);
      check_val("rst_valid", 32'(cfg_valid_o), 32'd0);
      check_val("rst_busy",  32'(busy_o),      32'd0);
      check_val("rst_done",  32'(done_o),      32'd0);
      check_val("rst_data",  cfg_data_o,       32'h0);
      check_val("rst_state", 32'(dbg_state_o), 32'd0);
      rst_i = 1'b0;
      @(negedge clk_i);

      // Basic transfer
      clear_logs();
      ready_en = 1'b1;
      do_start(32'h0000_1000, 10'd3);
      check_val("basic_first_req",  32'(obi_req_o), 32'd1);
      check_val("basic_first_addr", obi_addr_o,     32'h0000_1000);
      check_val("basic_we",         32'(obi_we_o),  32'd0);
      check_val("basic_be",         32'(obi_be_o),  32'hF);
      check_val("basic_wdata",      obi_wdata_o,    32'h0);
      check_val("basic_busy",       32'(busy_o),    32'd1);
      wait_done("basic", 100);
      repeat (3) @(negedge clk_i);
      check_xfer("basic", 32'h0000_1000, 3);
      check_val("basic_done_pulses", 32'(done_cnt), 32'd1);
      check_val("basic_busy_after",  32'(busy_o),   32'd0);

      // Backpressure: FIFO fills, requests stop at the credit limit
      clear_logs();
      ready_en = 1'b0;
      do_start(32'h0000_2000, 10'd8);
      repeat (15) @(negedge clk_i);
      check_val("bp_grants_stalled", 32'(grant_cnt),   32'd4);
      check_val("bp_req_low",        32'(obi_req_o),   32'd0);
      check_val("bp_valid",          32'(cfg_valid_o), 32'd1);
      check_val("bp_head_data",      cfg_data_o,       mem_word(32'h0000_2000));
      check_val("bp_head_last",      32'(cfg_last_o),  32'd0);
      repeat (3) @(negedge clk_i);
      check_val("bp_head_hold",      cfg_data_o,       mem_word(32'h0000_2000));
      ready_en = 1'b1;
      wait_done("bp", 200);
      repeat (3) @(negedge clk_i);
      check_xfer("bp", 32'h0000_2000, 8);
      check_val("bp_max_inflight",   32'(max_inflight), 32'd4);
      check_val("bp_done_pulses",    32'(done_cnt),     32'd1);

      // Delayed grant: each request waits 5 cycles with stable address
      clear_logs();
      gnt_delay = 5;
      do_start(32'h0000_6000, 10'd2);
      wait_done("dly", 200);
      gnt_delay = 0;
      repeat (3) @(negedge clk_i);
      check_val("dly_stall_cycles", 32'(stall_cycles), 32'd10);
      check_val("dly_stable",       32'(stable_err),   32'd0);
      check_val("dly_grants",       32'(grant_cnt),    32'd2);
      check_xfer("dly", 32'h0000_6000, 2);

      // Zero count
      clear_logs();
      do_start(32'h0000_7000, 10'd0);
      check_val("zero_done",  32'(done_o), 32'd1);
      check_val("zero_busy",  32'(busy_o), 32'd0);
      @(negedge clk_i);
      check_val("zero_done_fall", 32'(done_o), 32'd0);
      repeat (3) @(negedge clk_i);
      check_val("zero_no_req",    32'(req_seen), 32'd0);
      check_val("zero_busy_after", 32'(busy_o),  32'd0);
      check_val("zero_pulses",    32'(done_cnt), 32'd1);

      // Start while busy is ignored
      clear_logs();
      gnt_delay = 1;
      do_start(32'h0000_3000, 10'd4);
      @(negedge clk_i);
      check_val("busy_mid", 32'(busy_o), 32'd1);
      do_start(32'h0000_9000, 10'd7);
      wait_done("busy", 200);
      gnt_delay = 0;
      repeat (5) @(negedge clk_i);
      check_val("busy_done_pulses", 32'(done_cnt), 32'd1);
      check_val("busy_idle_after",  32'(busy_o),   32'd0);
      check_xfer("busy", 32'h0000_3000, 4);

      // Reset during FETCH
      clear_logs();
      ready_en = 1'b0;
      do_start(32'h0000_4000, 10'd8);
      @(negedge clk_i);
      check_val("mid_busy_before", 32'(busy_o), 32'd1);
      rst_i = 1'b1;
      #1;
      check_val("mid_rst_req",   32'(obi_req_o),   32'd0);
      check_val("mid_rst_valid", 32'(cfg_valid_o), 32'd0);
      check_val("mid_rst_busy",  32'(busy_o),      32'd0);
      check_val("mid_rst_state", 32'(dbg_state_o), 32'd0);
      repeat (2) @(negedge clk_i);
      rst_i = 1'b0;
      @(negedge clk_i);
      clear_logs();
      ready_en = 1'b1;

      // Fresh start after reset, with address wrap
      do_start(32'hFFFF_FFF8, 10'd3);
      check_val("wrap_first_addr", obi_addr_o, 32'hFFFF_FFF8);
      wait_done("wrap", 100);
      repeat (3) @(negedge clk_i);
      check_xfer("wrap", 32'hFFFF_FFF8, 3);

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
